rvb_shifter_issue: RTL
======================

# rvb_shifter_issue

Issue-side front end for the bit-manipulation shifter unit: accepts raw RISC-V instruction words with operands and a destination tag, queues them, decodes the instruction bits the unit consumes, and drives the unit's `din_*` handshake. It captures the unit's `dout_rd` into a tagged result register with its own valid/ready handshake. It sits between the core's execute dispatch and the shifter datapath.

## Interface
Parameters:
- `XLEN`, 64 — operand width, 32 or 64.
- `DEPTH`, 2 — issue-queue entries, power of two, ≥2.
- `TAGW`, 5 — destination tag width.

Ports:
- `clock`  in  1  — positive-edge clock; single clock domain.
- `reset`  in  1  — asynchronous, active-high reset.
- `in_valid`  in  1  — instruction offered.
- `in_ready`  out  1  — queue accepts instruction.
- `in_insn`  in  32  — instruction word.
- `in_rs1`, `in_rs2`, `in_rs3`  in  XLEN  — operand values.
- `in_tag`  in  TAGW  — destination tag.
- `u_din_valid`  out  1  — head instruction presented to unit.
- `u_din_ready`  in  1  — unit accepts input.
- `u_rs1`, `u_rs2`, `u_rs3`  out  XLEN  — unit operands.
- `u_insn3`, `u_insn14`, `u_insn26`, `u_insn27`, `u_insn29`, `u_insn30`  out  1  — decoded instruction bits.
- `u_dout_valid`  in  1  — unit result valid.
- `u_dout_ready`  out  1  — result slot can accept.
- `u_dout_rd`  in  XLEN  — unit result.
- `res_valid`  out  1  — result register full.
- `res_ready`  in  1  — consumer takes result.
- `res_rd`  out  XLEN  — result value.
- `res_tag`  out  TAGW  — result tag.
- `res_illegal`  out  1  — instruction rejected; see Configuration.

## Operation
- Queue: circular buffer with `DEPTH` entries, wrapping read/write pointers, and a count. Enqueue occurs on `in_valid && in_ready`. `in_ready = (count < DEPTH)`; there is no bypass when full, even if a dequeue happens in the same cycle.
- Head decode is combinational from the head entry:
  - `u_insnN = insn[N]`.
  - `u_rs1` and `u_rs3` pass through.
  - `u_rs2`: register forms (opcode 0110011 or 0111011) pass `rs2`. Immediate forms (0010011 or 0011011) drive `u_rs2` with `insn[25:20]` zero-extended to XLEN.
- `u_din_valid = (count != 0)`, unless the head is illegal (see Configuration).
- `u_dout_ready = !res_valid || res_ready`. It never depends on `u_din_ready`, so no combinational loop forms with a pass-through unit.
- Retire: the head dequeues and loads the result register when `u_dout_valid && u_dout_ready` and the queue is non-empty. The load writes `res_rd = u_dout_rd`, `res_tag = head tag`, and `res_illegal = 0`.
- The result register clears `res_valid` on `res_valid && res_ready`, unless a new result loads in the same cycle.
- Enqueue and retire in the same cycle leave the count unchanged and move both pointers.
- Reset, asynchronous:
  - Queue empties and pointers go to 0.
  - `res_valid`, `res_rd`, `res_tag`, `res_illegal` go to 0.
  - Resulting output values: `in_ready = 1`, `u_din_valid = 0`, `u_dout_ready = 1`.
  - Reset mid-transaction discards all queued and held instructions; nothing is emitted.

## Timing
- Latency with an empty queue and a zero-latency unit:
  - Instruction accepted in cycle N.
  - Presented on `u_*` in cycle N+1.
  - `res_valid` high in cycle N+2.
- Sustained throughput is one instruction per cycle when `res_ready` is held high.
- `u_*` outputs are stable while `u_din_valid && !u_din_ready`.
- `res_*` outputs are stable while `res_valid && !res_ready`.
- When the result slot is stalled, the queue fills to `DEPTH`, then `in_ready` drops in the following cycle.

## Configuration
- `RVB_SHIFTER_ISSUE_ILLEGAL_EN` defined — the head is illegal if any of the following hold:
  - opcode is not one of the four listed;
  - `insn[14:12]` is not 001 or 101;
  - `XLEN == 32 && insn[3]`.
- Handling of an illegal head: `u_din_valid` is 0 for it. It retires when `u_dout_ready`, loading `res_rd = 0`, its tag, and `res_illegal = 1`.
- Macro not defined: every entry goes to the unit and `res_illegal` is tied to 0.

## Test plan
- Reset, then a single ROR (0x60005033-class OP, rs1=0x1, rs2=1) with a pass-through unit model → `res_valid` at N+2, `res_tag` matching, `u_insn30=1`, `u_insn29=1`, `u_insn14=1`.
- SLLI with `insn[25:20]=35` and `in_rs2=0xFFFF` → `u_rs2 = 35`, `u_insn3 = 0`.
- Hold `res_ready=0` and offer 4 instructions → exactly 1 result held plus `DEPTH` queued; `in_ready` is 0. Then release → results emerge in order with tags 0,1,2,3.
- Back-to-back stream of 16 instructions with `res_ready=1` → one result per cycle, no bubbles, tags in order.
- With `RVB_SHIFTER_ISSUE_ILLEGAL_EN` defined, offer opcode 0x03 (load) → `u_din_valid` stays 0, `res_illegal=1`, `res_rd=0`. Without the macro, the same instruction reaches the unit.
- Assert `reset` while queue holds 2 entries and `res_valid=1` → all valids 0 immediately, without waiting for a clock edge. After release, a new instruction completes normally.

Source files
------------

// File: rtl/rvb_shifter_issue.sv
// rvb_shifter_issue: issue-side front end for the bit-manipulation shifter unit.
// Queues raw instruction words with operands and a destination tag, decodes the
// instruction bits the unit consumes from the queue head, drives the unit's din
// handshake, and captures the unit's result into a tagged result register.
//
// Ports:
//   clock, reset               - clock, asynchronous active-high reset
//   in_valid/in_ready          - instruction enqueue handshake
//   in_insn, in_rs1..3, in_tag - instruction word, operands, destination tag
//   u_din_valid/u_din_ready    - head presented to the unit
//   u_rs1..3, u_insnN          - unit operands and decoded instruction bits
//   u_dout_valid/u_dout_ready  - unit result handshake
//   u_dout_rd                  - unit result
//   res_valid/res_ready        - result register handshake
//   res_rd, res_tag            - held result and its tag
//   res_illegal                - held entry was rejected without reaching the unit
//
// Build option: define RVB_SHIFTER_ISSUE_ILLEGAL_EN to reject unsupported
// instructions at the head; otherwise every entry goes to the unit.

`timescale 1ns/1ps

module rvb_shifter_issue #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAGW  = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_rs3,
  input  logic [TAGW-1:0] in_tag,
  output logic            u_din_valid,
  input  logic            u_din_ready,
  output logic [XLEN-1:0] u_rs1,
  output logic [XLEN-1:0] u_rs2,
  output logic [XLEN-1:0] u_rs3,
  output logic            u_insn3,
  output logic            u_insn14,
  output logic            u_insn26,
  output logic            u_insn27,
  output logic            u_insn29,
  output logic            u_insn30,
  input  logic            u_dout_valid,
  output logic            u_dout_ready,
  input  logic [XLEN-1:0] u_dout_rd,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_rd,
  output logic [TAGW-1:0] res_tag,
  output logic            res_illegal
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Queue storage; contents are don't-care while the slot is empty.
  logic [31:0]     insn_mem [DEPTH];
  logic [XLEN-1:0] rs1_mem  [DEPTH];
  logic [XLEN-1:0] rs2_mem  [DEPTH];
  logic [XLEN-1:0] rs3_mem  [DEPTH];
  logic [TAGW-1:0] tag_mem  [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            res_valid_q, res_valid_d;
  logic [XLEN-1:0] res_rd_q, res_rd_d;
  logic [TAGW-1:0] res_tag_q, res_tag_d;

  logic [31:0] head_insn;
  logic [6:0]  opcode;
  logic        is_reg, is_imm;
  logic        not_empty, head_illegal;
  logic        enq, retire;

  assign head_insn = insn_mem[rd_ptr_q];
  assign opcode    = head_insn[6:0];
  assign is_reg    = (opcode == 7'b0110011) || (opcode == 7'b0111011);
  assign is_imm    = (opcode == 7'b0010011) || (opcode == 7'b0011011);
  assign not_empty = (count_q != '0);

`ifdef RVB_SHIFTER_ISSUE_ILLEGAL_EN
  localparam bit Xlen32 = (XLEN == 32);
  assign head_illegal = !(is_reg || is_imm)
                     || !((head_insn[14:12] == 3'b001) || (head_insn[14:12] == 3'b101))
                     || (Xlen32 && head_insn[3]);
`else
  assign head_illegal = 1'b0;
`endif

  // Instruction bits the unit never looks at.
  logic unused_insn_bits;
  assign unused_insn_bits = ^{head_insn[31], head_insn[28], head_insn[19:7], is_reg};

  // Head decode and unit interface.
  assign u_rs1    = rs1_mem[rd_ptr_q];
  assign u_rs3    = rs3_mem[rd_ptr_q];
  assign u_rs2    = is_imm ? {{(XLEN-6){1'b0}}, head_insn[25:20]} : rs2_mem[rd_ptr_q];
  assign u_insn3  = head_insn[3];
  assign u_insn14 = head_insn[14];
  assign u_insn26 = head_insn[26];
  assign u_insn27 = head_insn[27];
  assign u_insn29 = head_insn[29];
  assign u_insn30 = head_insn[30];

  assign u_din_valid  = not_empty && !head_illegal;
  // Independent of u_din_ready so a pass-through unit cannot close a loop.
  assign u_dout_ready = !res_valid_q || res_ready;

  // No enqueue while full, even if the head retires this cycle.
  assign in_ready = (count_q < CntW'(DEPTH));
  assign enq      = in_valid && in_ready;
  // An illegal head never reaches the unit, so it retires without u_dout_valid.
  assign retire   = not_empty && u_dout_ready && (head_illegal || u_dout_valid);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (retire) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (enq && !retire) count_d = count_q + CntW'(1);
    else if (!enq && retire) count_d = count_q - CntW'(1);
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_rd_d    = res_rd_q;
    res_tag_d   = res_tag_q;
    if (retire) begin
      res_valid_d = 1'b1;
      res_rd_d    = head_illegal ? '0 : u_dout_rd;
      res_tag_d   = tag_mem[rd_ptr_q];
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_rd_q    <= '0;
      res_tag_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_rd_q    <= res_rd_d;
      res_tag_q   <= res_tag_d;
    end
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      insn_mem[wr_ptr_q] <= in_insn;
      rs1_mem[wr_ptr_q]  <= in_rs1;
      rs2_mem[wr_ptr_q]  <= in_rs2;
      rs3_mem[wr_ptr_q]  <= in_rs3;
      tag_mem[wr_ptr_q]  <= in_tag;
    end
  end

`ifdef RVB_SHIFTER_ISSUE_ILLEGAL_EN
  logic res_illegal_q, res_illegal_d;

  always_comb begin
    res_illegal_d = res_illegal_q;
    if (retire) res_illegal_d = head_illegal;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) res_illegal_q <= 1'b0;
    else       res_illegal_q <= res_illegal_d;
  end

  assign res_illegal = res_illegal_q;
`else
  assign res_illegal = 1'b0;
`endif

  assign res_valid = res_valid_q;
  assign res_rd    = res_rd_q;
  assign res_tag   = res_tag_q;

endmodule
